// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive front end.
//   DATA_W               character width in bits
//   DEFAULT_CLKS_PER_BIT default baud divisor (50 MHz / 115200)
//   rx_state_e           receiver FSM states
//   clog2                ceil(log2(value)) for sizing pointers and counters
package uart_pkg;

  localparam int unsigned DATA_W               = 8;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } rx_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    int unsigned v;
    result = 0;
    v      = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with extra-bit pointers.
//   clk, resetn      clock, asynchronous active-low reset
//   push_i, data_i   write strobe and data; dropped when full unless a pop lands in the same cycle
//   pop_i            read strobe; ignored while empty
//   data_o           head entry, forced to 0 while empty
//   empty_o, full_o  occupancy flags
//   count_o          entries held, 0..FIFO_DEPTH
module sync_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push_i,
  input  logic [DATA_W-1:0]            data_i,
  input  logic                         pop_i,
  output logic [DATA_W-1:0]            data_o,
  output logic                         empty_o,
  output logic                         full_o,
  output logic [clog2(FIFO_DEPTH):0]   count_o
);

  localparam int unsigned AW = clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, rd_ptr_q;
  logic              do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign empty_o = (count_o == '0);
  assign full_o  = (count_o == (AW+1)'(FIFO_DEPTH));

  assign do_pop  = pop_i && !empty_o;
  // When full, a same-cycle pop frees the head slot that the push then reuses.
  assign do_push = push_i && (!full_o || do_pop);

  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with byte FIFO.
// Synchronises rx_i, deframes 8N1 characters (8E1 when UART_RX_PARITY_EN is defined) and
// buffers good bytes in a show-ahead FIFO drained by rd_en_i.
//   clk, resetn    clock, asynchronous active-low reset
//   rx_i           asynchronous serial line, idles high
//   rd_en_i        pop head byte (ignored while empty)
//   rd_data_o      head byte, valid while empty_o=0
//   empty_o        FIFO empty
//   full_o         FIFO full
//   count_o        bytes held
//   frame_err_o    1-cycle pulse, stop bit sampled low
//   overrun_o      1-cycle pulse, good byte dropped on full FIFO
//   parity_err_o   1-cycle pulse, even-parity mismatch (only with UART_RX_PARITY_EN)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        rx_i,
  input  logic                        rd_en_i,
  output logic [DATA_W-1:0]           rd_data_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [clog2(FIFO_DEPTH):0]  count_o,
  output logic                        frame_err_o,
  output logic                        overrun_o
`ifdef UART_RX_PARITY_EN
  ,
  output logic                        parity_err_o
`endif
);

  localparam logic [15:0] BitLast  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HalfLast = 16'(CLKS_PER_BIT / 2 - 1);

  logic              rx_meta_q, rxs_q, rxs_prev_q;
  rx_state_e         state_q;
  logic [15:0]       baud_q;
  logic [2:0]        bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic              stop_sample;
  logic              push;
`ifdef UART_RX_PARITY_EN
  logic              parity_bad_q;
  logic              parity_err_q;
`endif

  // Two-stage synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx_i;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  assign stop_sample = (state_q == StStop) && (baud_q == BitLast);
`ifdef UART_RX_PARITY_EN
  assign push = stop_sample && rxs_q && !parity_bad_q;
`else
  assign push = stop_sample && rxs_q;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      frame_err_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          baud_q <= '0;
          bit_q  <= '0;
          if (!rxs_q && rxs_prev_q) state_q <= StStart;
        end
        StStart: begin
          if (baud_q == HalfLast) begin
            baud_q  <= '0;
            // A start bit that is high again at its centre was a glitch.
            state_q <= rxs_q ? StIdle : StData;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        StData: begin
          if (baud_q == BitLast) begin
            baud_q  <= '0;
            shift_q <= {rxs_q, shift_q[DATA_W-1:1]};
            if (bit_q == 3'd7) begin
              bit_q   <= '0;
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        StParity: begin
          if (baud_q == BitLast) begin
            baud_q       <= '0;
`ifdef UART_RX_PARITY_EN
            // Even parity: the parity bit equals the XOR of the data bits.
            parity_bad_q <= (rxs_q != (^shift_q));
`endif
            state_q      <= StStop;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        StStop: begin
          if (baud_q == BitLast) begin
            baud_q <= '0;
            if (!rxs_q) begin
              frame_err_q <= 1'b1;
              state_q     <= StBreak;
            end else begin
`ifdef UART_RX_PARITY_EN
              parity_err_q <= parity_bad_q;
`endif
              state_q <= StIdle;
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        StBreak: begin
          // Hold here until the line recovers so a long break reports once.
          baud_q <= '0;
          if (rxs_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push && full_o && !rd_en_i;
    end
  end

  sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .data_i  (shift_q),
    .pop_i   (rd_en_i),
    .data_o  (rd_data_o),
    .empty_o (empty_o),
    .full_o  (full_o),
    .count_o (count_o)
  );

  assign frame_err_o  = frame_err_q;
  assign overrun_o    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err_o = parity_err_q;
`endif

endmodule
